// File: rtl/xsim_dma_read_arbiter.sv
// Round-robin arbiter that turns per-client read bursts into single-beat DMA reads,
// one outstanding read at a time, and returns each beat tagged with its owning client.
module xsim_dma_read_arbiter #(
    parameter int NCLIENT = 4,
    parameter int LENW    = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NCLIENT-1:0]           req_valid,
    output logic [NCLIENT-1:0]           req_ready,
    input  logic [NCLIENT*32-1:0]        req_handle,
    input  logic [NCLIENT*32-1:0]        req_addr,
    input  logic [NCLIENT*LENW-1:0]      req_len,
    input  logic                         dma_rdy_readrequest,
    output logic                         dma_en_readrequest,
    output logic [31:0]                  dma_readrequest_handle,
    output logic [31:0]                  dma_readrequest_addr,
    input  logic                         dma_rdy_readresponse,
    output logic                         dma_en_readresponse,
    input  logic [31:0]                  dma_readresponse_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic [$clog2(NCLIENT)-1:0]   rsp_client,
    output logic                         rsp_last,
    output logic                         busy
);
    localparam int CW = $clog2(NCLIENT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

    state_e          state_q;
    logic [CW-1:0]   ptr_q;
    logic [CW-1:0]   client_q;
    logic [31:0]     handle_q;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic [LENW-1:0] remain_q;

    logic [CW-1:0]   win;
    logic            any_win;
    logic            grant;
    logic [LENW-1:0] win_len;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
        int c;
        c = int'(base) + k;
        if (c >= NCLIENT) c = c - NCLIENT;
        return CW'(c);
    endfunction

    // Scan from ptr+NCLIENT down to ptr+1 so the closest requester after ptr wins.
    always_comb begin
        win     = ptr_q;
        any_win = 1'b0;
        for (int k = NCLIENT; k >= 1; k--) begin
            if (req_valid[rr_idx(ptr_q, k)]) begin
                win     = rr_idx(ptr_q, k);
                any_win = 1'b1;
            end
        end
    end

    // RST_N gates the grant so req_ready drops the instant reset asserts.
    assign grant   = RST_N && (state_q == IDLE) && any_win;
    assign win_len = req_len[win*LENW +: LENW];

    for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_ready
        assign req_ready[gi] = grant && (win == CW'(gi));
    end

    assign dma_en_readrequest     = (state_q == ISSUE) && dma_rdy_readrequest;
    assign dma_en_readresponse    = (state_q == WAIT) && dma_rdy_readresponse;
    assign dma_readrequest_handle = handle_q;
    assign dma_readrequest_addr   = addr_q;
    assign rsp_valid              = (state_q == DELIVER);
    assign rsp_data               = data_q;
    assign rsp_client             = client_q;
    assign rsp_last               = rsp_valid && (remain_q == LENW'(1));
    assign busy                   = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ptr_q    <= CW'(NCLIENT - 1);
            client_q <= '0;
            handle_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            remain_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_win) begin
                        ptr_q <= win;
                        // Zero-length bursts are consumed here and never reach the DMA.
                        if (win_len != '0) begin
                            client_q <= win;
                            handle_q <= req_handle[win*32 +: 32];
                            addr_q   <= req_addr[win*32 +: 32];
                            remain_q <= win_len;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (dma_rdy_readrequest) state_q <= WAIT;
                end
                WAIT: begin
                    if (dma_rdy_readresponse) begin
                        data_q  <= dma_readresponse_data;
                        state_q <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (rsp_ready) begin
                        remain_q <= remain_q - LENW'(1);
                        addr_q   <= addr_q + 32'd4;
                        state_q  <= (remain_q == LENW'(1)) ? IDLE : ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xsim_dma_read_arbiter.sv
// Scoreboard bench: grants are predicted by a round-robin model, every expected read and
// response beat is queued at grant time and popped by independent DMA and response monitors.
module tb_xsim_dma_read_arbiter;
    localparam int NC = 4;
    localparam int LW = 8;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_ready;
    logic [NC*32-1:0]  req_handle;
    logic [NC*32-1:0]  req_addr;
    logic [NC*LW-1:0]  req_len;
    logic              dma_rdy_readrequest;
    logic              dma_en_readrequest;
    logic [31:0]       dma_readrequest_handle;
    logic [31:0]       dma_readrequest_addr;
    logic              dma_rdy_readresponse;
    logic              dma_en_readresponse;
    logic [31:0]       dma_readresponse_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_client;
    logic              rsp_last;
    logic              busy;

    xsim_dma_read_arbiter #(.NCLIENT(NC), .LENW(LW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_handle(req_handle), .req_addr(req_addr), .req_len(req_len),
        .dma_rdy_readrequest(dma_rdy_readrequest), .dma_en_readrequest(dma_en_readrequest),
        .dma_readrequest_handle(dma_readrequest_handle), .dma_readrequest_addr(dma_readrequest_addr),
        .dma_rdy_readresponse(dma_rdy_readresponse), .dma_en_readresponse(dma_en_readresponse),
        .dma_readresponse_data(dma_readresponse_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_client(rsp_client), .rsp_last(rsp_last), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          client;
        bit          last;
        int          exp_cyc;
        bit          timed;
    } beat_t;

    typedef struct {
        logic [31:0] handle;
        logic [31:0] addr;
    } rd_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          mptr = NC - 1;
    int          grant_cnt = 0;
    int          done_cnt = 0;
    beat_t       beat_q[$];
    rd_t         rd_q[$];
    int          grant_log[$];
    int          grant_cyc_log[$];
    logic [NC-1:0] granted_vec = '0;
    bit          det = 1'b0;
    bit          rsp_low = 1'b0;
    bit          stall_resp = 1'b0;
    bit          pending = 1'b0;
    logic [31:0] pend_data = '0;
    int          exp_ord[5] = '{0, 1, 2, 3, 0};

    // Memory image seen through the DMA: a fixed scramble of handle and byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] h, input logic [31:0] a);
        return (h * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Arbitration model: predicts req_ready and queues the reads/beats each burst implies.
    always @(negedge CLK) begin
        logic [NC-1:0] exp_rdy;
        int            win;
        int            len;
        logic [31:0]   h;
        logic [31:0]   a;
        logic [31:0]   ak;
        granted_vec = '0;
        if (!RST_N) begin
            mptr = NC - 1;
            grant_cnt <= 0;
        end else begin
            exp_rdy = '0;
            win = -1;
            if (grant_cnt == done_cnt) begin
                for (int k = 1; k <= NC; k++)
                    if (win < 0 && req_valid[(mptr + k) % NC]) win = (mptr + k) % NC;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            if (req_ready != '0 || exp_rdy != '0) chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(grant_cnt != done_cnt));
            granted_vec = req_ready;
            if (win >= 0) begin
                mptr = win;
                grant_log.push_back(win);
                grant_cyc_log.push_back(cyc);
                h   = req_handle[win*32 +: 32];
                a   = req_addr[win*32 +: 32];
                len = int'(req_len[win*LW +: LW]);
                $display("grant  cycle %0d client %0d handle %08h addr %08h len %0d", cyc, win, h, a, len);
                for (int k = 0; k < len; k++) begin
                    ak = a + 32'(4 * k);
                    rd_q.push_back('{handle: h, addr: ak});
                    beat_q.push_back('{data: mem_word(h, ak), client: win, last: (k == len - 1),
                                       exp_cyc: cyc + 3 * (k + 1), timed: det && !rsp_low});
                end
                if (len > 0) grant_cnt <= grant_cnt + 1;
            end
        end
    end

    // Response monitor: pops one expected beat per handshake and checks stalls hold steady.
    bit          hv = 1'b0;
    logic [31:0] hd;
    logic [1:0]  hc;
    logic        hl;
    always @(negedge CLK) begin
        beat_t e;
        if (!RST_N) begin
            beat_q.delete();
            done_cnt <= 0;
            hv = 1'b0;
        end else begin
            if (hv) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_data", rsp_data, hd);
                chk("hold_client", 32'(rsp_client), 32'(hc));
                chk("hold_last", 32'(rsp_last), 32'(hl));
            end
            if (rsp_valid && rsp_ready) begin
                if (beat_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    e = beat_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_client", 32'(rsp_client), 32'(e.client));
                    chk("rsp_last", 32'(rsp_last), 32'(e.last));
                    if (e.timed) chk("rsp_cycle", 32'(cyc), 32'(e.exp_cyc));
                    $display("beat   cycle %0d client %0d data %08h last %0d", cyc, rsp_client, rsp_data, rsp_last);
                    if (e.last) done_cnt <= done_cnt + 1;
                end
            end
            hv = rsp_valid && !rsp_ready;
            hd = rsp_data;
            hc = rsp_client;
            hl = rsp_last;
        end
    end

    // DMA model: checks each issued read against the queue and serves its data.
    always @(negedge CLK) begin
        rd_t r;
        if (!RST_N) begin
            rd_q.delete();
            pending = 1'b0;
        end else begin
            if (dma_en_readrequest || dma_en_readresponse)
                chk("en_exclusive", 32'(dma_en_readrequest && dma_en_readresponse), 32'd0);
            if (dma_en_readrequest) begin
                if (rd_q.size() == 0) begin
                    fail_now("unexpected_read");
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_handle", dma_readrequest_handle, r.handle);
                    chk("rd_addr", dma_readrequest_addr, r.addr);
                end
                $display("read   cycle %0d handle %08h addr %08h", cyc, dma_readrequest_handle, dma_readrequest_addr);
                pending   = 1'b1;
                pend_data = mem_word(dma_readrequest_handle, dma_readrequest_addr);
            end
            if (dma_en_readresponse) pending = 1'b0;
        end
    end

    initial begin
        dma_rdy_readrequest   = 1'b0;
        dma_rdy_readresponse  = 1'b0;
        dma_readresponse_data = '0;
        rsp_ready             = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            dma_rdy_readrequest   = det ? 1'b1 : ($urandom_range(0, 3) != 0);
            dma_rdy_readresponse  = pending && !stall_resp && (det || $urandom_range(0, 2) != 0);
            dma_readresponse_data = pending ? pend_data : $urandom();
            rsp_ready             = rsp_low ? 1'b0 : (det ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        req_valid = req_valid & ~granted_vec;
    endtask

    task automatic set_req(input int c, input logic [31:0] h, input logic [31:0] a, input int len);
        req_valid[c]           = 1'b1;
        req_handle[c*32 +: 32] = h;
        req_addr[c*32 +: 32]   = a;
        req_len[c*LW +: LW]    = LW'(len);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((req_valid != '0 || grant_cnt != done_cnt) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) fail_now(name);
    endtask

    task automatic reset_pulse();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_en_rdreq"}, 32'(dma_en_readrequest), 32'd0);
        chk({tag, "_en_rdrsp"}, 32'(dma_en_readresponse), 32'd0);
        chk({tag, "_rd_handle"}, dma_readrequest_handle, 32'd0);
        chk({tag, "_rd_addr"}, dma_readrequest_addr, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_client"}, 32'(rsp_client), 32'd0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        RST_N      = 1'b0;
        req_valid  = '0;
        req_handle = '0;
        req_addr   = '0;
        req_len    = '0;
        for (int c = 0; c < NC; c++) set_req(c, 32'(c + 1), 32'h40 * c, 2);
        #23;
        check_reset_outputs("por");
        req_valid = '0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        det = 1'b1;
        tick();

        // Single client 1 burst of three at full rate.
        grant_log.delete();
        set_req(1, 32'd5, 32'h100, 3);
        wait_idle("t1_timeout", 100);
        chk("t1_grant_client", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);

        // All clients requesting length 1 continuously out of reset.
        for (int c = 0; c < NC; c++) set_req(c, 32'h20 + 32'(c), 32'h1000 * c, 1);
        reset_pulse();
        grant_log.delete();
        repeat (24) begin
            tick();
            req_valid = '1;
        end
        req_valid = '0;
        wait_idle("t2_timeout", 100);
        for (int k = 0; k < 5; k++)
            chk("t2_grant_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFFFFFF, 32'(exp_ord[k]));

        // Zero-length grant to client 0 followed straight away by client 3.
        reset_pulse();
        grant_log.delete();
        grant_cyc_log.delete();
        set_req(0, 32'd7, 32'h200, 0);
        set_req(3, 32'd9, 32'h300, 1);
        wait_idle("t3_timeout", 100);
        chk("t3_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFFFFFF, 32'd0);
        chk("t3_second_grant", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFFFFFF, 32'd3);
        chk("t3_grant_gap", (grant_cyc_log.size() > 1) ? 32'(grant_cyc_log[1] - grant_cyc_log[0]) : 32'hFFFFFFFF, 32'd1);

        // Address wraps from the top of the space to zero.
        set_req(1, 32'h33, 32'hFFFFFFFC, 2);
        wait_idle("t4_timeout", 100);

        // First beat stalled by rsp_ready for five cycles.
        rsp_low = 1'b1;
        set_req(2, 32'h44, 32'h400, 2);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail_now("t5_no_beat");
        repeat (5) begin
            @(negedge CLK);
            chk("t5_valid_held", 32'(rsp_valid), 32'd1);
            chk("t5_no_new_read", 32'(dma_en_readrequest), 32'd0);
            chk("t5_client", 32'(rsp_client), 32'd2);
        end
        rsp_low = 1'b0;
        wait_idle("t5_timeout", 100);

        // Reset asserted while a length-4 burst waits for its first response.
        reset_pulse();
        stall_resp = 1'b1;
        set_req(2, 32'h55, 32'h500, 4);
        repeat (5) tick();
        chk("t6_busy_in_wait", 32'(busy), 32'd1);
        set_req(0, 32'h66, 32'h600, 1);
        set_req(3, 32'h77, 32'h700, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(posedge CLK);
        #1;
        stall_resp = 1'b0;
        grant_log.delete();
        RST_N = 1'b1;
        wait_idle("t6_timeout", 100);
        chk("t6_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFFFFFF, 32'd0);
        chk("t6_second_grant", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFFFFFF, 32'd3);

        // Random traffic with random back-pressure; idle clients carry junk on their fields.
        det = 1'b0;
        repeat (1200) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (!req_valid[c]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(c, $urandom(),
                                ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC),
                                int'($urandom_range(0, 4)));
                    else begin
                        req_handle[c*32 +: 32] = $urandom();
                        req_addr[c*32 +: 32]   = $urandom();
                        req_len[c*LW +: LW]    = LW'($urandom());
                    end
                end
            end
        end
        wait_idle("drain_timeout", 4000);
        chk("drain_beats_left", 32'(beat_q.size()), 32'd0);
        chk("drain_reads_left", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/xsim_dma_read_arbiter.md
XSIM_DMA_READ_ARBITER -- requirements
Module: xsim_dma_read_arbiter

Interface
REQ-001 Parameter NCLIENT, default 4, number of read requesters (2..8).
REQ-002 Parameter LENW, default 8, burst-length field width in beats.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports are:
- CLK  in  1  clock, all state updates on posedge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  NCLIENT  per-client burst request.
- req_ready  out  NCLIENT  per-client accept pulse, at most one bit set.
- req_handle  in  NCLIENT*32  per-client DMA handle, client i in bits [32i+31:32i].
- req_addr  in  NCLIENT*32  per-client start byte address.
- req_len  in  NCLIENT*LENW  per-client beat count.
- dma_rdy_readrequest  in  1  DMA model can take a read.
- dma_en_readrequest  out  1  DMA read issue strobe.
- dma_readrequest_handle  out  32  handle for issued read.
- dma_readrequest_addr  out  32  address for issued read.
- dma_rdy_readresponse  in  1  DMA read data valid.
- dma_en_readresponse  out  1  DMA read data consume strobe.
- dma_readresponse_data  in  32  DMA read data.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  response beat accepted.
- rsp_data  out  32  response beat data.
- rsp_client  out  $clog2(NCLIENT)  owning client index.
- rsp_last  out  1  final beat of burst.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, DELIVER; exactly one read is outstanding downstream at any time.
REQ-005 IDLE: if any req_valid bit is set, the block SHALL grant round-robin starting at client (ptr+1) mod NCLIENT, assert req_ready for the winner for exactly that cycle, capture handle/addr/len and the client index, and set ptr to the winner.
REQ-006 A grant with req_len==0 SHALL be accepted and discarded: no downstream read, no rsp beat, state stays IDLE, ptr still advances.
REQ-007 A grant with req_len>0 SHALL move to ISSUE the next cycle; req_ready SHALL be 0 in every non-IDLE state.
REQ-008 ISSUE: dma_en_readrequest SHALL equal dma_rdy_readrequest (combinational), with dma_readrequest_handle/addr driven from the captured registers; on fire go to WAIT, otherwise hold.
REQ-009 WAIT: when dma_rdy_readresponse is 1, the block SHALL assert dma_en_readresponse that cycle, register dma_readresponse_data into rsp_data, and go to DELIVER.
REQ-010 DELIVER: rsp_valid SHALL be 1 with rsp_data, rsp_client, rsp_last stable until rsp_ready; rsp_last SHALL be 1 iff remaining beat count equals 1.
REQ-011 On DELIVER handshake: remaining decrements, addr increments by 4 modulo 2^32 (wrap 0xFFFFFFFC -> 0x00000000); go to IDLE if it was the last beat, else ISSUE.
REQ-012 With rdy inputs held high, a burst SHALL produce its first rsp_valid 3 cycles after the req_ready cycle and one beat every 3 cycles thereafter.
REQ-013 Changes on req_* inputs while req_ready is 0 SHALL have no effect; a client must hold req_valid until granted.
REQ-014 dma_en_readrequest and dma_en_readresponse SHALL never both be 1 in the same cycle.

Reset
REQ-015 RST_N low SHALL immediately force IDLE, ptr=NCLIENT-1 (client 0 wins first), remaining=0, and drive req_ready=0, dma_en_readrequest=0, dma_en_readresponse=0, dma_readrequest_handle=0, dma_readrequest_addr=0, rsp_valid=0, rsp_data=0, rsp_client=0, rsp_last=0, busy=0.
REQ-016 Reset mid-burst SHALL abandon the burst without further beats; the DMA model shares the same reset so no stale response survives.

Verification
REQ-017 Client 1 only, handle 5, addr 0x100, len 3, rdy and rsp_ready high -> reads at 0x100/0x104/0x108, rsp_valid at grant+3/+6/+9, rsp_client=1, rsp_last only on third.
REQ-018 All 4 clients request len 1 continuously from reset -> grant order 0,1,2,3,0.
REQ-019 Client 2 len 2, rsp_ready low 5 cycles on beat 1 -> rsp_data/rsp_client held, no second dma_en_readrequest until handshake.
REQ-020 Client 0 len 0 with client 3 len 1 pending -> client 0 req_ready pulse, no DMA traffic, client 3 granted next cycle.
REQ-021 addr 0xFFFFFFFC len 2 -> second read at 0x00000000.
REQ-022 RST_N low during WAIT of a len-4 burst -> all outputs 0 asynchronously, busy=0, next grant goes to client 0.
